vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 121 ++++++++++++
 tb/tb_vga_timing_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA-style raster timing generator: pixel-clock divider, x/y raster counters,
// sync/active-area decode with an optional pixel-tick delay line, and line/frame strobes.
module vga_timing_gen #(
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_PULSE = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_PULSE = 2,
  parameter int V_BP    = 33,
  parameter int CW      = 10,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int PIX_DIV = 1,
  parameter int LEAD    = 0
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_en,
  output logic [CW-1:0] o_x_counter,
  output logic [CW-1:0] o_y_counter,
  output logic          o_pix_ce,
  output logic          o_video,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_sol,
  output logic          o_sof
);

  localparam int H_TOTAL = H_DISP + H_FP + H_PULSE + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_PULSE + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VID_LAST = CW'(H_DISP - 1);
  localparam logic [CW-1:0] V_VID_LAST = CW'(V_DISP - 1);
  localparam logic [CW-1:0] HS_FIRST   = CW'(H_DISP + H_FP);
  localparam logic [CW-1:0] HS_LAST    = CW'(H_DISP + H_FP + H_PULSE - 1);
  localparam logic [CW-1:0] VS_FIRST   = CW'(V_DISP + V_FP);
  localparam logic [CW-1:0] VS_LAST    = CW'(V_DISP + V_FP + V_PULSE - 1);
  localparam logic [3:0]    DIV_LAST   = 4'(PIX_DIV - 1);

  logic [3:0]    div_q, div_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          tick;
  logic          vid_c, hs_act_c, vs_act_c;
  logic          vid_l, hs_act_l, vs_act_l;

  assign tick = i_en && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    if (i_en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 4'd1;
      if (tick) begin
        if (x_q == H_LAST) begin
          x_d = '0;
          y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
        end else begin
          x_d = x_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign vid_c    = (x_q <= H_VID_LAST) && (y_q <= V_VID_LAST);
  assign hs_act_c = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
  assign vs_act_c = (y_q >= VS_FIRST) && (y_q <= VS_LAST);

  // Delay line holds active-high flags; polarity is applied only at the pins.
  if (LEAD == 0) begin : g_nolead
    assign vid_l    = vid_c;
    assign hs_act_l = hs_act_c;
    assign vs_act_l = vs_act_c;
  end else begin : g_lead
    logic [LEAD-1:0] vid_pipe_q, hs_pipe_q, vs_pipe_q;

    always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
        vid_pipe_q <= '0;
        hs_pipe_q  <= '0;
        vs_pipe_q  <= '0;
      end else if (tick) begin
        vid_pipe_q <= (vid_pipe_q << 1) | LEAD'(vid_c);
        hs_pipe_q  <= (hs_pipe_q << 1)  | LEAD'(hs_act_c);
        vs_pipe_q  <= (vs_pipe_q << 1)  | LEAD'(vs_act_c);
      end
    end

    assign vid_l    = vid_pipe_q[LEAD-1];
    assign hs_act_l = hs_pipe_q[LEAD-1];
    assign vs_act_l = vs_pipe_q[LEAD-1];
  end

  // Outputs are forced to their idle values for as long as reset is held.
  assign o_pix_ce    = i_rstn && tick;
  assign o_x_counter = i_rstn ? x_q : '0;
  assign o_y_counter = i_rstn ? y_q : '0;
  assign o_video     = i_rstn && vid_l;
  assign o_hsync     = (i_rstn && hs_act_l) ? HS_POL : ~HS_POL;
  assign o_vsync     = (i_rstn && vs_act_l) ? VS_POL : ~VS_POL;
  assign o_sol       = o_pix_ce && (x_q == '0);
  assign o_sof       = o_sol && (y_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: five parameterisations driven from one clock, checked
// cycle by cycle against a tick-count raster model plus table rows and corner sequences.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn [5];
  logic       en   [5];
  logic [9:0] xo   [5];
  logic [9:0] yo   [5];
  logic       ce   [5];
  logic       vid  [5];
  logic       hs   [5];
  logic       vs   [5];
  logic       sol  [5];
  logic       sof  [5];

  vga_timing_gen #(.H_DISP(8), .H_FP(2), .H_PULSE(3), .H_BP(2), .V_DISP(4), .V_FP(1),
    .V_PULSE(2), .V_BP(1), .CW(10), .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(1), .LEAD(0)) u0 (
    .i_clk(clk), .i_rstn(rstn[0]), .i_en(en[0]), .o_x_counter(xo[0]), .o_y_counter(yo[0]),
    .o_pix_ce(ce[0]), .o_video(vid[0]), .o_hsync(hs[0]), .o_vsync(vs[0]), .o_sol(sol[0]), .o_sof(sof[0]));

  vga_timing_gen #(.H_DISP(8), .H_FP(2), .H_PULSE(3), .H_BP(2), .V_DISP(4), .V_FP(1),
    .V_PULSE(2), .V_BP(1), .CW(10), .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(3), .LEAD(0)) u1 (
    .i_clk(clk), .i_rstn(rstn[1]), .i_en(en[1]), .o_x_counter(xo[1]), .o_y_counter(yo[1]),
    .o_pix_ce(ce[1]), .o_video(vid[1]), .o_hsync(hs[1]), .o_vsync(vs[1]), .o_sol(sol[1]), .o_sof(sof[1]));

  vga_timing_gen #(.H_DISP(8), .H_FP(2), .H_PULSE(3), .H_BP(2), .V_DISP(4), .V_FP(1),
    .V_PULSE(2), .V_BP(1), .CW(10), .HS_POL(1'b1), .VS_POL(1'b0), .PIX_DIV(1), .LEAD(2)) u2 (
    .i_clk(clk), .i_rstn(rstn[2]), .i_en(en[2]), .o_x_counter(xo[2]), .o_y_counter(yo[2]),
    .o_pix_ce(ce[2]), .o_video(vid[2]), .o_hsync(hs[2]), .o_vsync(vs[2]), .o_sol(sol[2]), .o_sof(sof[2]));

  vga_timing_gen #(.H_DISP(8), .H_FP(2), .H_PULSE(3), .H_BP(2), .V_DISP(4), .V_FP(1),
    .V_PULSE(2), .V_BP(1), .CW(10), .HS_POL(1'b1), .VS_POL(1'b0), .PIX_DIV(1), .LEAD(0)) u3 (
    .i_clk(clk), .i_rstn(rstn[3]), .i_en(en[3]), .o_x_counter(xo[3]), .o_y_counter(yo[3]),
    .o_pix_ce(ce[3]), .o_video(vid[3]), .o_hsync(hs[3]), .o_vsync(vs[3]), .o_sol(sol[3]), .o_sof(sof[3]));

  vga_timing_gen u4 (
    .i_clk(clk), .i_rstn(rstn[4]), .i_en(en[4]), .o_x_counter(xo[4]), .o_y_counter(yo[4]),
    .o_pix_ce(ce[4]), .o_video(vid[4]), .o_hsync(hs[4]), .o_vsync(vs[4]), .o_sol(sol[4]), .o_sof(sof[4]));

  typedef struct {
    int pd, lead, hd, hfp, hp, hbp, vd, vfp, vp, vbp;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    int x, y;
    bit ce, video, hs, vs, sol, sof;
  } exp_t;

  typedef struct {
    bit   rstn, en;
    exp_t e;
  } vec_t;

  cfg_t cfg [5];
  exp_t sb [$];
  vec_t tbl [26];
  int   checks = 0;
  int   errors = 0;
  int   sol_ks [$];
  int   sof_ks [$];
  int   vid_ticks, rise_x, fall_x;

  // Expected outputs in the k-th cycle after reset release with enable held high.
  function automatic exp_t model(cfg_t c, int k);
    exp_t e;
    int ht, vt, t, td, xd, yd;
    bit va, ha, sa;
    ht = c.hd + c.hfp + c.hp + c.hbp;
    vt = c.vd + c.vfp + c.vp + c.vbp;
    t  = k / c.pd;
    e.ce = ((k % c.pd) == c.pd - 1);
    e.x  = t % ht;
    e.y  = (t / ht) % vt;
    va = 1'b0; ha = 1'b0; sa = 1'b0;
    if (t >= c.lead) begin
      td = t - c.lead;
      xd = td % ht;
      yd = (td / ht) % vt;
      va = (xd < c.hd) && (yd < c.vd);
      ha = (xd >= c.hd + c.hfp) && (xd < c.hd + c.hfp + c.hp);
      sa = (yd >= c.vd + c.vfp) && (yd < c.vd + c.vfp + c.vp);
    end
    e.video = va;
    e.hs    = ha ? c.hpol : !c.hpol;
    e.vs    = sa ? c.vpol : !c.vpol;
    e.sol   = e.ce && (e.x == 0);
    e.sof   = e.sol && (e.y == 0);
    return e;
  endfunction

  function automatic exp_t reset_exp(cfg_t c);
    exp_t e;
    e.x = 0; e.y = 0; e.ce = 1'b0; e.video = 1'b0;
    e.hs = !c.hpol; e.vs = !c.vpol; e.sol = 1'b0; e.sof = 1'b0;
    return e;
  endfunction

  task automatic check_out(int i, exp_t e, string name, int k);
    checks++;
    if (xo[i] !== 10'(e.x) || yo[i] !== 10'(e.y) || ce[i] !== e.ce || vid[i] !== e.video ||
        hs[i] !== e.hs || vs[i] !== e.vs || sol[i] !== e.sol || sof[i] !== e.sof) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s u%0d k=%0d got x=%0d y=%0d ce=%b vid=%b hs=%b vs=%b sol=%b sof=%b want x=%0d y=%0d ce=%b vid=%b hs=%b vs=%b sol=%b sof=%b",
          name, i, k, xo[i], yo[i], ce[i], vid[i], hs[i], vs[i], sol[i], sof[i],
          e.x, e.y, e.ce, e.video, e.hs, e.vs, e.sol, e.sof);
    end
  endtask

  task automatic expect_int(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic drive_cycle(int i, bit r, bit e_n, exp_t e, string name, int k);
    exp_t got;
    @(posedge clk);
    #1;
    rstn[i] = r;
    en[i]   = e_n;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    check_out(i, got, name, k);
  endtask

  task automatic reset_inst(int i);
    @(posedge clk);
    #1;
    rstn[i] = 1'b0;
    en[i]   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_out(i, reset_exp(cfg[i]), "reset_state", 0);
  endtask

  task automatic run_stream(int i, int n, string name);
    bit prev;
    sol_ks.delete();
    sof_ks.delete();
    vid_ticks = 0;
    rise_x = -1;
    fall_x = -1;
    prev = 1'b0;
    for (int k = 0; k < n; k++) begin
      drive_cycle(i, 1'b1, 1'b1, model(cfg[i], k), name, k);
      if (sol[i]) sol_ks.push_back(k);
      if (sof[i]) sof_ks.push_back(k);
      if (ce[i] && vid[i]) vid_ticks++;
      if (yo[i] == 10'd0 && vid[i] && !prev && rise_x < 0) rise_x = int'(xo[i]);
      if (yo[i] == 10'd0 && !vid[i] && prev && fall_x < 0) fall_x = int'(xo[i]);
      prev = vid[i];
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t hold;
    for (int i = 0; i < 5; i++) begin
      rstn[i] = 1'b0;
      en[i]   = 1'b0;
    end
    cfg[0] = '{pd: 1, lead: 0, hd: 8, hfp: 2, hp: 3, hbp: 2, vd: 4, vfp: 1, vp: 2, vbp: 1, hpol: 1'b0, vpol: 1'b0};
    cfg[1] = cfg[0];
    cfg[1].pd = 3;
    cfg[2] = cfg[0];
    cfg[2].lead = 2;
    cfg[2].hpol = 1'b1;
    cfg[3] = cfg[0];
    cfg[3].hpol = 1'b1;
    cfg[4] = '{pd: 1, lead: 0, hd: 640, hfp: 16, hp: 96, hbp: 48, vd: 480, vfp: 10, vp: 2, vbp: 33, hpol: 1'b0, vpol: 1'b0};

    // Pause at x=5,y=2, resume, then reset mid-frame (with and without enable).
    hold = '{x: 5, y: 2, ce: 1'b0, video: 1'b1, hs: 1'b1, vs: 1'b1, sol: 1'b0, sof: 1'b0};
    for (int j = 0; j < 20; j++) tbl[j] = '{rstn: 1'b1, en: 1'b0, e: hold};
    hold.ce = 1'b1;
    tbl[20] = '{rstn: 1'b1, en: 1'b1, e: hold};
    hold.x = 6;
    tbl[21] = '{rstn: 1'b1, en: 1'b1, e: hold};
    tbl[22] = '{rstn: 1'b0, en: 1'b1, e: reset_exp(cfg[0])};
    tbl[23] = '{rstn: 1'b0, en: 1'b0, e: reset_exp(cfg[0])};
    tbl[24] = '{rstn: 1'b1, en: 1'b1, e: model(cfg[0], 0)};
    tbl[25] = '{rstn: 1'b1, en: 1'b1, e: model(cfg[0], 1)};

    reset_inst(0);
    run_stream(0, 275, "stream_div1");
    expect_int("sof_period_div1", (sof_ks.size() >= 2) ? sof_ks[1] - sof_ks[0] : -1, 120);
    expect_int("sol_period_div1", (sol_ks.size() >= 2) ? sol_ks[1] - sol_ks[0] : -1, 15);
    for (int j = 0; j < 26; j++)
      drive_cycle(0, tbl[j].rstn, tbl[j].en, tbl[j].e, "table_pause_reset", j);

    reset_inst(1);
    run_stream(1, 726, "stream_div3");
    expect_int("first_sof_div3", (sof_ks.size() >= 1) ? sof_ks[0] : -1, 2);
    expect_int("sof_period_div3", (sof_ks.size() >= 2) ? sof_ks[1] - sof_ks[0] : -1, 360);

    reset_inst(2);
    run_stream(2, 130, "stream_lead2");
    expect_int("video_rise_x_lead2", rise_x, 2);
    expect_int("video_fall_x_lead2", fall_x, 10);

    reset_inst(3);
    run_stream(3, 101, "stream_hspol1");
    drive_cycle(3, 1'b0, 1'b1, reset_exp(cfg[3]), "reset_assert_x11", 0);
    drive_cycle(3, 1'b0, 1'b1, reset_exp(cfg[3]), "reset_next_cycle", 1);
    drive_cycle(3, 1'b1, 1'b1, model(cfg[3], 0), "reset_release", 2);

    reset_inst(4);
    run_stream(4, 1600, "stream_default");
    expect_int("sol_period_default", (sol_ks.size() >= 2) ? sol_ks[1] - sol_ks[0] : -1, 800);
    expect_int("video_ticks_2lines", vid_ticks, 1280);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
